// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   // Width of the step counter that runs 0..width-1.
   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_shift_add_mult_rca.sv
// WIDTH-bit ripple-carry adder built from full-adder cells, with carry-out.
module mult_rca #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] carry;

   assign carry[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
         assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
         assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier with valid/ready handshakes on both sides.
// Signed operands are reduced to magnitudes on accept; the sign is re-applied
// once the unsigned product is complete.
module seq_shift_add_mult
   import mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   mult_state_t        state_reg, state_next;
   logic [CW-1:0]      cnt_reg;
   logic [WIDTH-1:0]   mcand_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [2*WIDTH-1:0] product_reg;
   logic               neg_reg;
   // Set after the last add/shift step; the following cycle applies the sign
   // so the negation incrementer never sits in series with the adder.
   logic               fin_reg;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   rca_sum;
   logic               rca_cout;
   logic [2*WIDTH-1:0] step_acc;

   // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
   assign a_neg = in_signed & in_a[WIDTH-1];
   assign b_neg = in_signed & in_b[WIDTH-1];
   assign a_mag = a_neg ? (~in_a + WIDTH'(1)) : in_a;
   assign b_mag = b_neg ? (~in_b + WIDTH'(1)) : in_b;

   // Add the multiplicand into the upper half when the multiplier LSB is set.
   assign addend = acc_reg[0] ? mcand_reg : '0;

   mult_rca #(.WIDTH(WIDTH)) u_rca (
      .a    (acc_reg[2*WIDTH-1:WIDTH]),
      .b    (addend),
      .sum  (rca_sum),
      .cout (rca_cout)
   );

   // Keep the carry and shift right by one in the same step.
   assign step_acc = {rca_cout, rca_sum, acc_reg[WIDTH-1:1]};

   assign in_ready    = (state_reg == IDLE);
   assign out_valid   = (state_reg == DONE);
   assign out_product = product_reg;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: accept, finish stepping, hand the result over.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid)  state_next = CALC;
         CALC:    if (fin_reg)   state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: latch operands, run WIDTH add/shift steps, then sign the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg     <= '0;
         mcand_reg   <= '0;
         acc_reg     <= '0;
         product_reg <= '0;
         neg_reg     <= 1'b0;
         fin_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  mcand_reg <= a_mag;
                  acc_reg   <= {{WIDTH{1'b0}}, b_mag};
                  neg_reg   <= a_neg ^ b_neg;
                  cnt_reg   <= '0;
                  fin_reg   <= 1'b0;
               end
            end
            CALC: begin
               if (fin_reg) begin
                  // Two's-complement of zero is zero, so no special case needed.
                  product_reg <= neg_reg ? (~acc_reg + (2*WIDTH)'(1)) : acc_reg;
                  fin_reg     <= 1'b0;
               end else begin
                  acc_reg <= step_acc;
                  if (cnt_reg == CNT_LAST) begin
                     fin_reg <= 1'b1;
                  end else begin
                     cnt_reg <= cnt_reg + CW'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench: directed WIDTH=4 cases and a randomised WIDTH=8 run,
// with expected products held in a scoreboard queue.
module tb_seq_shift_add_mult;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // WIDTH=4 instance
   logic       v4, ir4, s4, ov4, or4;
   logic [3:0] a4, b4;
   logic [7:0] p4;

   // WIDTH=8 instance
   logic        v8, ir8, s8, ov8, or8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   int checks = 0;
   int errors = 0;
   logic [15:0] sb_q[$];

   seq_shift_add_mult #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_signed(s4),
      .in_a(a4), .in_b(b4), .out_valid(ov4), .out_ready(or4), .out_product(p4)
   );

   seq_shift_add_mult #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .in_signed(s8),
      .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(or8), .out_product(p8)
   );

   task automatic chk(input string tag, input string what, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s %s observed=%h expected=%h", tag, what, obs, expv);
      end
   endtask

   function automatic logic [15:0] ref8(input bit s, input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] sa, sb;
      sa = s ? {{8{a[7]}}, a} : {8'h00, a};
      sb = s ? {{8{b[7]}}, b} : {8'h00, b};
      return 16'(sa * sb);
   endfunction

   // One WIDTH=4 transaction: accept, count edges to the result, optional
   // stall in DONE, optional in_valid poke during CALC.
   task automatic txn4(input string tag, input bit s, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] expv, input int stall, input int poke);
      logic [15:0] q;
      logic [7:0]  held;
      @(negedge clk);
      chk(tag, "in_ready_idle", 16'(ir4), 16'd1);
      v4 = 1'b1; s4 = s; a4 = a; b4 = b; or4 = (stall == 0);
      sb_q.push_back({8'h00, expv});
      @(posedge clk); #1;
      // Scramble inputs to prove operands and mode were latched on accept.
      v4 = 1'b0; s4 = ~s; a4 = ~a; b4 = ~b;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         v4 = 1'b0;
         if (k == poke) begin
            chk(tag, "in_ready_calc", 16'(ir4), 16'd0);
            v4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
         end
         if (k == 4) chk(tag, "out_valid_early", 16'(ov4), 16'd0);
      end
      v4 = 1'b0;
      chk(tag, "out_valid_latency", 16'(ov4), 16'd1);
      if (sb_q.size() == 0) begin
         chk(tag, "scoreboard_empty", 16'd0, 16'd1);
      end else begin
         q = sb_q.pop_front();
         chk(tag, "product", {8'h00, p4}, q);
      end
      held = p4;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk(tag, "stall_valid", 16'(ov4), 16'd1);
         chk(tag, "stall_hold", {8'h00, p4}, {8'h00, held});
         chk(tag, "stall_in_ready", 16'(ir4), 16'd0);
      end
      or4 = 1'b1;
      @(posedge clk); #1;
      chk(tag, "valid_drop", 16'(ov4), 16'd0);
      chk(tag, "in_ready_back", 16'(ir4), 16'd1);
      or4 = 1'b0;
      $display("txn %s signed=%0d a=%h b=%h product=%h", tag, s, a, b, held);
   endtask

   initial begin
      logic [15:0] q;
      logic        sr;
      logic [7:0]  ra, rb;
      int          cyc;
      bit          got;

      rst_n = 1'b0;
      v4 = 0; s4 = 0; a4 = 0; b4 = 0; or4 = 0;
      v8 = 0; s8 = 0; a8 = 0; b8 = 0; or8 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", "in_ready", 16'(ir4), 16'd1);
      chk("reset", "out_valid", 16'(ov4), 16'd0);
      chk("reset", "product", {8'h00, p4}, 16'h0000);
      chk("reset", "in_ready8", 16'(ir8), 16'd1);
      chk("reset", "product8", p8, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      txn4("u15x15", 1'b0, 4'd15, 4'd15, 8'hE1, 0, 0);
      txn4("sm8xm8", 1'b1, 4'h8, 4'h8, 8'h40, 0, 0);
      txn4("sm3x5", 1'b1, 4'hD, 4'h5, 8'hF1, 0, 0);
      txn4("s0xm1", 1'b1, 4'h0, 4'hF, 8'h00, 0, 0);
      txn4("bp6x7", 1'b0, 4'd6, 4'd7, 8'h2A, 3, 0);
      txn4("busy7x9", 1'b0, 4'd7, 4'd9, 8'd63, 0, 2);
      txn4("after_busy", 1'b1, 4'hF, 4'h7, 8'hF9, 0, 0);

      // Abort an operation with reset in the middle of CALC.
      @(negedge clk);
      v4 = 1'b1; s4 = 1'b0; a4 = 4'd5; b4 = 4'd5; or4 = 1'b1;
      @(posedge clk); #1;
      v4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort", "out_valid", 16'(ov4), 16'd0);
      chk("abort", "in_ready", 16'(ir4), 16'd1);
      chk("abort", "product", {8'h00, p4}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      or4 = 1'b0;
      $display("txn abort a=5 b=5 discarded");
      txn4("post_reset3x3", 1'b0, 4'd3, 4'd3, 8'd9, 0, 0);

      // WIDTH=8 random operands, mode and consumer stalls.
      for (int t = 0; t < 1000; t++) begin
         sr = 1'($urandom_range(0, 1));
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (t == 0) begin sr = 1'b0; ra = 8'hFF; rb = 8'hFF; end
         if (t == 1) begin sr = 1'b1; ra = 8'h80; rb = 8'h80; end
         @(negedge clk);
         v8 = 1'b1; s8 = sr; a8 = ra; b8 = rb;
         sb_q.push_back(ref8(sr, ra, rb));
         @(posedge clk); #1;
         v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~sr;
         cyc = 0;
         got = 1'b0;
         while (!got && cyc < 60) begin
            @(negedge clk);
            or8 = 1'($urandom_range(0, 1));
            if (ov8 && or8) begin
               got = 1'b1;
               if (sb_q.size() == 0) begin
                  chk("rand8", "scoreboard_empty", 16'd0, 16'd1);
               end else begin
                  q = sb_q.pop_front();
                  chk("rand8", "product", p8, q);
                  $display("txn rand8 #%0d signed=%0d a=%h b=%h product=%h", t, sr, ra, rb, p8);
               end
            end
            cyc++;
         end
         if (!got) chk("rand8", "timeout", 16'd0, 16'd1);
         @(posedge clk); #1;
         or8 = 1'b0;
         chk("rand8", "valid_drop", 16'(ov8), 16'd0);
      end
      chk("final", "scoreboard_left", 16'(sb_q.size()), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
